mul4_seq_ctrl: RTL and testbench

- FSM controller that sequences the 4x4 shift-and-add multiplier datapath, which contains:
  - 4-bit A/B input registers.
  - 2-to-1 nibble-half muxes.
  - A 2x2 multiplier.
  - A shift stage.
  - An 8-bit adder and an 8-bit accumulator register.
- Accepts a start request and drives all datapath control lines.
- Performs one operand load, then four partial-product accumulations, then reports completion.
- Sits between the top-level handshake and the datapath control pins.

---
 rtl/mul4_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_mul4_seq_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mul4_seq_ctrl.sv
// Sequencing controller for a 4x4 shift-and-add multiplier datapath.
// One operand load, four partial-product accumulations, then a one-cycle done pulse.
module mul4_seq_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic ld_A,
  output logic ld_B,
  output logic rst_out,
  output logic l_1,
  output logic l_2,
  output logic shctrl_1,
  output logic shctrl_0,
  output logic ld_out,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_P0   = 3'd2,
    S_P1   = 3'd3,
    S_P2   = 3'd4,
    S_P3   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  typedef struct packed {
    logic       ld_a;
    logic       ld_b;
    logic       rst_out;
    logic       l_1;
    logic       l_2;
    logic [1:0] sh;
    logic       ld_out;
    logic       busy;
    logic       done;
  } ctrl_t;

  state_t r_state;
  state_t w_next_state;
  ctrl_t  r_ctrl;

  // Output pattern for the state about to be entered, so outputs stay registered.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_LOAD: begin
        c.ld_a    = 1'b1;
        c.ld_b    = 1'b1;
        c.rst_out = 1'b1;
        c.busy    = 1'b1;
      end
      S_P0: begin
        c.sh     = 2'b00;
        c.ld_out = 1'b1;
        c.busy   = 1'b1;
      end
      S_P1: begin
        c.l_2    = 1'b1;
        c.sh     = 2'b01;
        c.ld_out = 1'b1;
        c.busy   = 1'b1;
      end
      S_P2: begin
        c.l_1    = 1'b1;
        c.sh     = 2'b01;
        c.ld_out = 1'b1;
        c.busy   = 1'b1;
      end
      S_P3: begin
        c.l_1    = 1'b1;
        c.l_2    = 1'b1;
        c.sh     = 2'b10;
        c.ld_out = 1'b1;
        c.busy   = 1'b1;
      end
      S_DONE:  c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: w_next_state = start ? S_LOAD : S_IDLE;
      S_LOAD: w_next_state = abort ? S_IDLE : S_P0;
      S_P0:   w_next_state = abort ? S_IDLE : S_P1;
      S_P1:   w_next_state = abort ? S_IDLE : S_P2;
      S_P2:   w_next_state = abort ? S_IDLE : S_P3;
      S_P3:   w_next_state = abort ? S_IDLE : S_DONE;
      // abort is deliberately not looked at here: a new start always wins.
      S_DONE: w_next_state = start ? S_LOAD : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next_state;
      r_ctrl  <= decode(w_next_state);
    end
  end

  assign ld_A     = r_ctrl.ld_a;
  assign ld_B     = r_ctrl.ld_b;
  assign rst_out  = r_ctrl.rst_out;
  assign l_1      = r_ctrl.l_1;
  assign l_2      = r_ctrl.l_2;
  assign shctrl_1 = r_ctrl.sh[1];
  assign shctrl_0 = r_ctrl.sh[0];
  assign ld_out   = r_ctrl.ld_out;
  assign busy     = r_ctrl.busy;
  assign done     = r_ctrl.done;

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// Self-checking bench for mul4_seq_ctrl: per-cycle control-line model plus a
// behavioural datapath driven by the DUT's control lines to check final products.
module tb_mul4_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ld_A, ld_B, rst_out, l_1, l_2, shctrl_1, shctrl_0, ld_out, busy, done;

  int checks = 0;
  int failures = 0;

  logic [3:0] tb_a = 4'd0;
  logic [3:0] tb_b = 4'd0;
  logic [3:0] dp_a = 4'd0;
  logic [3:0] dp_b = 4'd0;
  logic [7:0] dp_acc = 8'd0;
  logic [7:0] pp_shift;
  logic [1:0] half_a, half_b;

  // Transaction position: 0 = idle, 1 = load, 2..5 = partial products 0..3, 6 = done.
  int mdl_step = 0;

  mul4_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ld_A(ld_A), .ld_B(ld_B), .rst_out(rst_out), .l_1(l_1), .l_2(l_2),
    .shctrl_1(shctrl_1), .shctrl_0(shctrl_0), .ld_out(ld_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected {ld_A,ld_B,rst_out,l_1,l_2,shctrl_1,shctrl_0,ld_out,busy,done} per position.
  function automatic logic [9:0] exp_ctrl(input int step);
    case (step)
      1:       return 10'b111_00_00_0_1_0;
      2:       return 10'b000_00_00_1_1_0;
      3:       return 10'b000_01_01_1_1_0;
      4:       return 10'b000_10_01_1_1_0;
      5:       return 10'b000_11_10_1_1_0;
      6:       return 10'b000_00_00_0_0_1;
      default: return 10'b000_00_00_0_0_0;
    endcase
  endfunction

  function automatic logic [9:0] dut_ctrl();
    return {ld_A, ld_B, rst_out, l_1, l_2, shctrl_1, shctrl_0, ld_out, busy, done};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst)
      mdl_step <= 0;
    else if (mdl_step == 0 || mdl_step == 6)
      mdl_step <= start ? 1 : 0;
    else if (abort)
      mdl_step <= 0;
    else
      mdl_step <= mdl_step + 1;
  end

  always @(negedge clk) chk("ctrl", int'(dut_ctrl()), int'(exp_ctrl(mdl_step)));

  // Datapath: operand registers, half muxes, 2x2 multiply, shift, accumulate.
  assign half_a = l_1 ? dp_a[3:2] : dp_a[1:0];
  assign half_b = l_2 ? dp_b[3:2] : dp_b[1:0];
  assign pp_shift = ({shctrl_1, shctrl_0} == 2'b01) ? (8'(half_a * half_b) << 2) :
                    ({shctrl_1, shctrl_0} == 2'b10) ? (8'(half_a * half_b) << 4) :
                    8'(half_a * half_b);

  always @(posedge clk) begin
    if (ld_A) dp_a <= tb_a;
    if (ld_B) dp_b <= tb_b;
    if (rst_out) dp_acc <= 8'd0;
    else if (ld_out) dp_acc <= dp_acc + pp_shift;
  end

  task automatic wait_done(input string name, input int exp_prod);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    chk({name, "_done"}, int'(got), 1);
    chk({name, "_lat"}, n, 6);
    chk({name, "_prod"}, int'(dp_acc), exp_prod);
    $display("txn %s: product=%0d latency=%0d", name, dp_acc, n);
  endtask

  task automatic run(input string name, input int a, input int b, input int exp_prod);
    tb_a = 4'(a);
    tb_b = 4'(b);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(name, exp_prod);
  endtask

  task automatic wait_phase(input string name, input logic want_l1, input logic want_l2);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (busy && ld_out && l_1 == want_l1 && l_2 == want_l2) got = 1'b1;
    end
    chk(name, int'(got), 1);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", int'(dut_ctrl()), 0);
    #2 rst = 1'b1;

    repeat (10) @(negedge clk);
    chk("idle_outs", int'(dut_ctrl()), 0);
    $display("txn idle: outputs=0x%0h", dut_ctrl());

    run("m13x11", 13, 11, 143);
    run("m15x15", 15, 15, 225);
    run("m0x9", 0, 9, 0);
    run("m4x8", 4, 8, 32);

    // Back-to-back: start held high across both transactions.
    tb_a = 4'd3;
    tb_b = 4'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done("b2b_3x5", 15);
    tb_a = 4'd7;
    tb_b = 4'd6;
    wait_done("b2b_7x6", 42);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_idle", int'(busy), 0);

    // Abort during P2.
    tb_a = 4'd2;
    tb_b = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_phase("abort_p2_seen", 1'b1, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      chk("abort_nodone", int'(done), 0);
      @(negedge clk);
    end
    $display("txn abort: busy=%0d done=%0d", busy, done);
    run("m9x9", 9, 9, 81);

    // Asynchronous reset in the middle of P1.
    tb_a = 4'd6;
    tb_b = 4'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_phase("rst_p1_seen", 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1 chk("async_rst_outs", int'(dut_ctrl()), 0);
    $display("txn async_rst: outputs=0x%0h", dut_ctrl());
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    run("m10x12", 10, 12, 120);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
